// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing generator: timing presets, colour modes,
// control-bundle type and the colour helper functions.
package vga_pkg;

    localparam int VGA640_H_ACTIVE = 32'd640;
    localparam int VGA640_H_FRONT  = 32'd16;
    localparam int VGA640_H_PULSE  = 32'd96;
    localparam int VGA640_H_BACK   = 32'd48;
    localparam int VGA640_V_ACTIVE = 32'd480;
    localparam int VGA640_V_FRONT  = 32'd10;
    localparam int VGA640_V_PULSE  = 32'd2;
    localparam int VGA640_V_BACK   = 32'd33;

    // 800x600@72 (50 MHz pixel clock, both syncs active-high)
    localparam int VGA800_H_ACTIVE = 32'd800;
    localparam int VGA800_H_FRONT  = 32'd56;
    localparam int VGA800_H_PULSE  = 32'd120;
    localparam int VGA800_H_BACK   = 32'd64;
    localparam int VGA800_V_ACTIVE = 32'd600;
    localparam int VGA800_V_FRONT  = 32'd37;
    localparam int VGA800_V_PULSE  = 32'd6;
    localparam int VGA800_V_BACK   = 32'd23;

    typedef enum logic [1:0] {
        COLOR_GRAY8  = 2'd0,
        COLOR_RGB332 = 2'd1,
        COLOR_RGB888 = 2'd2
    } color_mode_e;

    typedef struct packed {
        logic blank;
        logic hsync;
        logic vsync;
    } vga_ctl_t;

    function automatic logic [23:0] decode_color(input logic [23:0] c, input color_mode_e mode);
        logic [23:0] rgb;
        case (mode)
            COLOR_RGB332: rgb = {c[7:5], c[7:5], c[7:6], c[4:2], c[4:2], c[4:3], {4{c[1:0]}}};
            COLOR_RGB888: rgb = c;
            default:      rgb = {3{c[7:0]}};
        endcase
        return rgb;
    endfunction

    // Colour-bar table: white, yellow, cyan, green, magenta, red, blue, black
    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] rgb;
        case (idx)
            3'd0:    rgb = 24'hFFFFFF;
            3'd1:    rgb = 24'hFFFF00;
            3'd2:    rgb = 24'h00FFFF;
            3'd3:    rgb = 24'h00FF00;
            3'd4:    rgb = 24'hFF00FF;
            3'd5:    rgb = 24'hFF0000;
            3'd6:    rgb = 24'h0000FF;
            default: rgb = 24'h000000;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter plus active-region and sync-pulse decode.
// Used once per pixel for the horizontal axis and once per line for the vertical axis.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int   ACTIVE = 640,
    parameter int   FRONT  = 16,
    parameter int   PULSE  = 96,
    parameter int   BACK   = 48,
    parameter logic POL    = 1'b0,
    parameter int   W      = 10
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         last,
    output logic         active,
    output logic         sync_lvl
);

    localparam int         TOTAL     = ACTIVE + FRONT + PULSE + BACK;
    // One extra bit so ACTIVE or TOTAL equal to 2**W still compare correctly
    localparam logic [W:0] LAST_C    = (W+1)'(TOTAL - 1);
    localparam logic [W:0] ACT_C     = (W+1)'(ACTIVE);
    localparam logic [W:0] SYNC_LO_C = (W+1)'(ACTIVE + FRONT);
    localparam logic [W:0] SYNC_HI_C = (W+1)'(ACTIVE + FRONT + PULSE);
    localparam logic [W-1:0] ONE_C   = W'(1);

    logic [W-1:0] count_r;
    logic [W:0]   count_ext_s;

    assign count_ext_s = {1'b0, count_r};

    // Position counter, wraps to zero after the last back-porch position
    always_ff @(posedge clock) begin
        if (!reset) begin
            count_r <= {W{1'b0}};
        end else if (en) begin
            if (last) begin
                count_r <= {W{1'b0}};
            end else begin
                count_r <= count_r + ONE_C;
            end
        end
    end

    assign count    = count_r;
    assign last     = (count_ext_s == LAST_C);
    assign active   = (count_ext_s < ACT_C);
    assign sync_lvl = ((count_ext_s >= SYNC_LO_C) && (count_ext_s < SYNC_HI_C)) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator with frame-buffer latency compensation and DAC colour pipeline.
// Optional VGA_TEST_PATTERN_EN adds input pattern_en and an eight-bar colour test pattern.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE   = VGA640_H_ACTIVE,
    parameter int   H_FRONT    = VGA640_H_FRONT,
    parameter int   H_PULSE    = VGA640_H_PULSE,
    parameter int   H_BACK     = VGA640_H_BACK,
    parameter int   V_ACTIVE   = VGA640_V_ACTIVE,
    parameter int   V_FRONT    = VGA640_V_FRONT,
    parameter int   V_PULSE    = VGA640_V_PULSE,
    parameter int   V_BACK     = VGA640_V_BACK,
    parameter logic HS_POL     = 1'b0,
    parameter logic VS_POL     = 1'b0,
    parameter int   LATENCY    = 2,
    parameter int   COLOR_MODE = 0,
    parameter int   CNT_W      = 10
) (
    input  logic             clock,
    input  logic             reset,
`ifdef VGA_TEST_PATTERN_EN
    input  logic             pattern_en,
`endif
    input  logic [23:0]      color_in,
    output logic [CNT_W-1:0] next_x,
    output logic [CNT_W-1:0] next_y,
    output logic             next_valid,
    output logic             line_start,
    output logic             frame_start,
    output logic [15:0]      frame_cnt,
    output logic             hsync,
    output logic             vsync,
    output logic             blank,
    output logic             sync,
    output logic             clk,
    output logic [7:0]       red,
    output logic [7:0]       green,
    output logic [7:0]       blue
);

    localparam color_mode_e MODE_C = (COLOR_MODE == 1) ? COLOR_RGB332 :
                                     (COLOR_MODE == 2) ? COLOR_RGB888 : COLOR_GRAY8;
    localparam vga_ctl_t CTL_IDLE_C = {1'b0, ~HS_POL, ~VS_POL};

    logic [CNT_W-1:0] h_count_s;
    logic [CNT_W-1:0] v_count_s;
    logic             h_last_s;
    logic             v_last_s;
    logic             h_active_s;
    logic             v_active_s;
    logic             hs_raw_s;
    logic             vs_raw_s;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE), .FRONT (H_FRONT), .PULSE (H_PULSE), .BACK (H_BACK),
        .POL    (HS_POL),   .W     (CNT_W)
    ) u_h_axis (
        .clock    (clock),
        .reset    (reset),
        .en       (1'b1),
        .count    (h_count_s),
        .last     (h_last_s),
        .active   (h_active_s),
        .sync_lvl (hs_raw_s)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE), .FRONT (V_FRONT), .PULSE (V_PULSE), .BACK (V_BACK),
        .POL    (VS_POL),   .W     (CNT_W)
    ) u_v_axis (
        .clock    (clock),
        .reset    (reset),
        .en       (h_last_s),
        .count    (v_count_s),
        .last     (v_last_s),
        .active   (v_active_s),
        .sync_lvl (vs_raw_s)
    );

    assign next_valid  = h_active_s & v_active_s;
    assign next_x      = next_valid ? h_count_s : {CNT_W{1'b0}};
    assign next_y      = next_valid ? v_count_s : {CNT_W{1'b0}};
    assign line_start  = (h_count_s == {CNT_W{1'b0}});
    assign frame_start = line_start & (v_count_s == {CNT_W{1'b0}});

    // Tap i feeds delay stage i; tap LATENCY is the pixel whose colour is on color_in now
    vga_ctl_t ctl_dly_r [LATENCY+1];
    vga_ctl_t ctl_tap_s [LATENCY+1];

    assign ctl_tap_s[0] = {next_valid, hs_raw_s, vs_raw_s};
    for (genvar i = 1; i <= LATENCY; i++) begin : g_ctl_tap
        assign ctl_tap_s[i] = ctl_dly_r[i-1];
    end

    // Blank/sync delay line, flushed to the idle level so no partial line follows reset
    always_ff @(posedge clock) begin
        for (int i = 0; i <= LATENCY; i++) begin
            if (!reset) begin
                ctl_dly_r[i] <= CTL_IDLE_C;
            end else begin
                ctl_dly_r[i] <= ctl_tap_s[i];
            end
        end
    end

    logic [23:0] pix_s;

`ifdef VGA_TEST_PATTERN_EN
    localparam int               BAR_W      = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;
    localparam logic [CNT_W-1:0] BAR_W_C    = CNT_W'(BAR_W);
    localparam logic [CNT_W-1:0] BAR_LAST_C = CNT_W'(7);

    logic [CNT_W-1:0] x_dly_r [LATENCY+1];
    logic [CNT_W-1:0] x_tap_s [LATENCY+1];
    logic [CNT_W-1:0] bar_q_s;
    logic [2:0]       bar_idx_s;

    assign x_tap_s[0] = next_x;
    for (genvar i = 1; i <= LATENCY; i++) begin : g_x_tap
        assign x_tap_s[i] = x_dly_r[i-1];
    end

    // Column delay line so the bars line up with frame-buffer pixels
    always_ff @(posedge clock) begin
        for (int i = 0; i <= LATENCY; i++) begin
            if (!reset) begin
                x_dly_r[i] <= {CNT_W{1'b0}};
            end else begin
                x_dly_r[i] <= x_tap_s[i];
            end
        end
    end

    assign bar_q_s = x_tap_s[LATENCY] / BAR_W_C;

    // Bar index, clamped for widths that are not a multiple of eight
    always_comb begin
        if (bar_q_s > BAR_LAST_C) begin
            bar_idx_s = 3'd7;
        end else begin
            bar_idx_s = bar_q_s[2:0];
        end
    end

    // Colour source select between test pattern and frame buffer
    always_comb begin
        if (pattern_en) begin
            pix_s = bar_color(bar_idx_s);
        end else begin
            pix_s = decode_color(color_in, MODE_C);
        end
    end
`else
    // Colour source is always the frame buffer
    always_comb begin
        pix_s = decode_color(color_in, MODE_C);
    end
`endif

    logic [23:0] rgb_r;
    logic [15:0] frame_cnt_r;

    // DAC colour register; dark whenever the aligned pixel is in blanking
    always_ff @(posedge clock) begin
        if (!reset) begin
            rgb_r <= 24'h000000;
        end else if (ctl_tap_s[LATENCY].blank) begin
            rgb_r <= pix_s;
        end else begin
            rgb_r <= 24'h000000;
        end
    end

    // Completed-frame counter, steps when both axes wrap together
    always_ff @(posedge clock) begin
        if (!reset) begin
            frame_cnt_r <= 16'h0000;
        end else if (h_last_s && v_last_s) begin
            frame_cnt_r <= frame_cnt_r + 16'h0001;
        end
    end

    assign frame_cnt = frame_cnt_r;
    assign blank     = ctl_dly_r[LATENCY].blank;
    assign hsync     = ctl_dly_r[LATENCY].hsync;
    assign vsync     = ctl_dly_r[LATENCY].vsync;
    assign red       = rgb_r[23:16];
    assign green     = rgb_r[15:8];
    assign blue      = rgb_r[7:0];
    assign sync      = 1'b0;
    assign clk       = clock;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three small-timing instances with different
// latency, colour mode, polarity and porch settings, randomized colour and resets.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    localparam int NCYC = 2500;
    localparam int HA   [3] = '{16, 10, 16};
    localparam int HF   [3] = '{2, 0, 1};
    localparam int HP   [3] = '{3, 2, 2};
    localparam int HB   [3] = '{1, 0, 3};
    localparam int VA   [3] = '{6, 3, 5};
    localparam int VF   [3] = '{1, 0, 2};
    localparam int VP   [3] = '{2, 1, 1};
    localparam int VB   [3] = '{1, 0, 1};
    localparam int LAT  [3] = '{2, 0, 7};
    localparam int MODE [3] = '{1, 2, 0};
    localparam bit [2:0] HSP = 3'b001;
    localparam bit [2:0] VSP = 3'b010;

    typedef struct packed {
        logic [1:0]  dut;
        logic        blank;
        logic        hs;
        logic        vs;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic [9:0]  nx;
        logic [9:0]  ny;
        logic        nv;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [23:0] color_in = 24'h000000;
`ifdef VGA_TEST_PATTERN_EN
    logic        pattern_en = 1'b0;
`endif

    logic [9:0]  nx_s [3];
    logic [9:0]  ny_s [3];
    logic        nv_s [3];
    logic        ls_s [3];
    logic        fs_s [3];
    logic [15:0] fc_s [3];
    logic        hs_s [3];
    logic        vs_s [3];
    logic        blank_s [3];
    logic        sync_s [3];
    logic        clk_s [3];
    logic [7:0]  r_s [3];
    logic [7:0]  g_s [3];
    logic [7:0]  b_s [3];

    exp_t sb_q [$];
    int   total = 0;
    int   bad = 0;
    bit   armed = 1'b0;

    always #5 clock = ~clock;

    for (genvar d = 0; d < 3; d++) begin : g_dut
        vga_timing_gen #(
            .H_ACTIVE (HA[d]), .H_FRONT (HF[d]), .H_PULSE (HP[d]), .H_BACK (HB[d]),
            .V_ACTIVE (VA[d]), .V_FRONT (VF[d]), .V_PULSE (VP[d]), .V_BACK (VB[d]),
            .HS_POL (HSP[d]), .VS_POL (VSP[d]), .LATENCY (LAT[d]),
            .COLOR_MODE (MODE[d]), .CNT_W (10)
        ) u_dut (
            .clock       (clock),
            .reset       (reset),
`ifdef VGA_TEST_PATTERN_EN
            .pattern_en  (pattern_en),
`endif
            .color_in    (color_in),
            .next_x      (nx_s[d]),
            .next_y      (ny_s[d]),
            .next_valid  (nv_s[d]),
            .line_start  (ls_s[d]),
            .frame_start (fs_s[d]),
            .frame_cnt   (fc_s[d]),
            .hsync       (hs_s[d]),
            .vsync       (vs_s[d]),
            .blank       (blank_s[d]),
            .sync        (sync_s[d]),
            .clk         (clk_s[d]),
            .red         (r_s[d]),
            .green       (g_s[d]),
            .blue        (b_s[d])
        );
    end

    // Colour decode from the mode rules written as arithmetic on channel values
    function automatic logic [23:0] ref_color(input int mode, input logic [23:0] c);
        int v, r3, g3, b2;
        v  = int'(c[7:0]);
        r3 = v / 32;
        g3 = (v / 4) % 8;
        b2 = v % 4;
        case (mode)
            1:       return {8'(r3 * 36 + r3 / 2), 8'(g3 * 36 + g3 / 2), 8'(b2 * 85)};
            2:       return c;
            default: return {c[7:0], c[7:0], c[7:0]};
        endcase
    endfunction

    // Expected pins after the coming edge, given edges since reset (cnt) and this cycle's inputs
    function automatic exp_t predict(input int d, input int cnt, input logic rst_n, input logic [23:0] c);
        exp_t e;
        int   ht, ft, p, x, y, nc;
        ht = HA[d] + HF[d] + HP[d] + HB[d];
        ft = ht * (VA[d] + VF[d] + VP[d] + VB[d]);
        e  = '0;
        e.dut = 2'(d);
        e.hs  = !HSP[d];
        e.vs  = !VSP[d];
        if (rst_n && cnt >= LAT[d]) begin
            p = (cnt - LAT[d]) % ft;
            x = p % ht;
            y = p / ht;
            e.blank = (x < HA[d]) && (y < VA[d]);
            if (x >= HA[d] + HF[d] && x < HA[d] + HF[d] + HP[d]) e.hs = HSP[d];
            if (y >= VA[d] + VF[d] && y < VA[d] + VF[d] + VP[d]) e.vs = VSP[d];
            if (e.blank) {e.r, e.g, e.b} = ref_color(MODE[d], c);
        end
        nc = rst_n ? cnt + 1 : 0;
        p  = nc % ft;
        x  = p % ht;
        y  = p / ht;
        e.nv = (x < HA[d]) && (y < VA[d]);
        e.nx = e.nv ? 10'(x) : 10'd0;
        e.ny = e.nv ? 10'(y) : 10'd0;
        e.ls = (x == 0);
        e.fs = (p == 0);
        e.fc = 16'(nc / ft);
        return e;
    endfunction

    task automatic cmp(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s dut%0d t=%0t: got %0h want %0h", name, d, $time, act, exp);
        end
    endtask

    // Stimulus: random colour every cycle, occasional reset bursts, expectations queued
    initial begin
        int cnt;
        int rst_left;
        logic rst_now;
        cnt = 0;
        rst_left = 3;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            int sel;
            @(negedge clock);
            if (rst_left == 0 && (cyc == 700 || $urandom_range(0, 299) == 0))
                rst_left = $urandom_range(1, 3);
            rst_now = (rst_left == 0);
            if (rst_left > 0) rst_left--;
            sel = $urandom_range(0, 7);
            reset = rst_now;
            color_in = (sel == 0) ? 24'h0000E3 : (sel == 1) ? 24'h123456 : 24'($urandom);
            for (int d = 0; d < 3; d++) sb_q.push_back(predict(d, cnt, rst_now, color_in));
            armed = 1'b1;
            cnt = rst_now ? cnt + 1 : 0;
        end
        @(posedge clock);
        #2;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d entries left want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Monitor: after each edge pop one expectation per instance and compare
    initial begin
        exp_t e;
        int   d;
        forever begin
            @(posedge clock);
            #1;
            if (armed) begin
                for (int k = 0; k < 3; k++) begin
                    if (sb_q.size() == 0) begin
                        cmp("queue", k, 64'd0, 64'd1);
                    end else begin
                        e = sb_q.pop_front();
                        d = int'(e.dut);
                        cmp("ctl", d, 64'({blank_s[d], hs_s[d], vs_s[d]}), 64'({e.blank, e.hs, e.vs}));
                        cmp("rgb", d, 64'({r_s[d], g_s[d], b_s[d]}), 64'({e.r, e.g, e.b}));
                        cmp("req", d, 64'({nv_s[d], nx_s[d], ny_s[d], ls_s[d], fs_s[d]}),
                            64'({e.nv, e.nx, e.ny, e.ls, e.fs}));
                        cmp("fcnt", d, 64'(fc_s[d]), 64'(e.fc));
                        cmp("pins", d, 64'({sync_s[d], clk_s[d]}), 64'({1'b0, clock}));
                    end
                end
            end
        end
    end

endmodule
